// File: rtl/counter_nbit_updown.sv
// rtl/counter_nbit_updown.sv - parametrised up/down counter with wrap or saturate mode
//
// Purpose:
//   General event/timer counter. Counts in the range 0..MOD_VALUE-1, either
//   wrapping or holding at the range ends, with synchronous clear and load,
//   terminal-count flags and a registered one-cycle wrap/saturation pulse.
//
// Parameters:
//   WIDTH      counter width in bits (>= 1)
//   MOD_VALUE  modulus, 2 <= MOD_VALUE <= 2**WIDTH
//   SATURATE   0 = wrap at range ends, 1 = hold at range ends
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   clear      synchronous clear to 0 (highest priority)
//   load       synchronous load of load_data (clamped to MOD_VALUE-1)
//   load_data  value to load
//   en         count enable, one step per enabled cycle
//   up         direction: 1 = increment, 0 = decrement
//   count      current count (registered)
//   at_max     count == MOD_VALUE-1 (combinational)
//   at_min     count == 0 (combinational)
//   event_o    registered one-cycle pulse on a wrap or blocked saturating step

module counter_nbit_updown #(
  parameter int WIDTH     = 4,
  parameter int MOD_VALUE = 2**WIDTH,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             event_o
);

  // Range limits are held in WIDTH+1 bits so MOD_VALUE = 2**WIDTH is representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD_VALUE);
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MOD_VALUE - 1);
  localparam logic [WIDTH-1:0] MAX_VAL = MAX_EXT[WIDTH-1:0];

  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   load_ext;
  logic [WIDTH-1:0] load_val;

  assign count_ext = {1'b0, count};
  assign load_ext  = {1'b0, load_data};

  // Out-of-range load values clamp to the top of the range.
  assign load_val = (load_ext >= MOD_EXT) ? MAX_VAL : load_data;

  assign at_max = (count_ext == MAX_EXT);
  assign at_min = (count == '0);

  // Increment only happens below MAX and decrement only above 0, so the
  // WIDTH-bit step can never overflow; the range ends are handled explicitly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      event_o <= 1'b0;
    end else if (clear) begin
      count   <= '0;
      event_o <= 1'b0;
    end else if (load) begin
      count   <= load_val;
      event_o <= 1'b0;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          event_o <= 1'b1;
          if (SATURATE == 0) count <= '0;
        end else begin
          event_o <= 1'b0;
          count   <= count + WIDTH'(1);
        end
      end else begin
        if (at_min) begin
          event_o <= 1'b1;
          if (SATURATE == 0) count <= MAX_VAL;
        end else begin
          event_o <= 1'b0;
          count   <= count - WIDTH'(1);
        end
      end
    end else begin
      event_o <= 1'b0;
    end
  end

endmodule
